fml_arbiter_2m: RTL

Two-master round-robin arbiter that shares one FML DDR slave port (the 16-bit DDR interface's bus side) between two FML requesters, e.g. the video framebuffer reader and the CPU/DMA path. It grants one master per transaction, holds the grant until the slave acknowledges, and returns the read data and acknowledge to the winning master only. A watchdog terminates transactions the slave never acknowledges and flags the error.

---
 rtl/fml_arbiter_2m.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fml_arbiter_2m.sv
// fml_arbiter_2m
// Two-master round-robin arbiter in front of one FML DDR slave port.
// One master is granted per transaction. The grant is held until the slave
// acknowledges or the watchdog expires. The ack and read data are then
// returned to the winning master only.
//
// Handshake: a master raises mN_stb with its request and holds it until the
// cycle in which mN_ack is high. It must drop stb on the edge that samples
// that ack. On the slave side, s_stb is held high until s_ack is seen; s_di
// is valid in the s_ack cycle. mN_do is valid only while mN_ack is high.
//
// Ports
//   sys_clk, sys_rst           clock, synchronous active-high reset
//   m0_*/m1_*                  master request (adr/stb/we/sel/di), ack/do back
//   s_adr/s_stb/s_we/s_sel/s_do  slave request
//   s_ack, s_di                slave acknowledge and read data
//   err                        sticky watchdog-abort flag
//   dbg_state                  current FSM state (IDLE=0, ACTIVE=1, DONE=2)
module fml_arbiter_2m #(
  parameter int          SDRAM_DEPTH = 26,
  parameter int          TIMEOUT     = 1024,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [SDRAM_DEPTH-1:0] m0_adr,
  input  logic                   m0_stb,
  input  logic                   m0_we,
  input  logic [3:0]             m0_sel,
  input  logic [31:0]            m0_di,
  output logic                   m0_ack,
  output logic [31:0]            m0_do,
  input  logic [SDRAM_DEPTH-1:0] m1_adr,
  input  logic                   m1_stb,
  input  logic                   m1_we,
  input  logic [3:0]             m1_sel,
  input  logic [31:0]            m1_di,
  output logic                   m1_ack,
  output logic [31:0]            m1_do,
  output logic [SDRAM_DEPTH-1:0] s_adr,
  output logic                   s_stb,
  output logic                   s_we,
  output logic [3:0]             s_sel,
  output logic [31:0]            s_do,
  input  logic                   s_ack,
  input  logic [31:0]            s_di,
  output logic                   err,
  output logic [1:0]             dbg_state
);

  localparam int                WDOG_W   = $clog2(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  logic              owner;
  logic              last;
  logic [WDOG_W-1:0] wdog;
  logic [31:0]       rd_buf;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;   // m0 wins the first tie
      wdog   <= '0;
      rd_buf <= 32'd0;
      err    <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_stb || m1_stb) begin
            // A tie goes to whoever was not served last; otherwise the
            // single requester wins.
            if (m0_stb && m1_stb) owner <= ~last;
            else                  owner <= m1_stb;
            wdog  <= '0;
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          // s_ack is tested first so it wins over a simultaneous timeout.
          if (s_ack) begin
            rd_buf <= s_di;
            m0_ack <= ~owner;
            m1_ack <= owner;
            state  <= DONE;
          end else if (wdog == WDOG_MAX) begin
            rd_buf <= ERR_DATA;
            err    <= 1'b1;
            m0_ack <= ~owner;
            m1_ack <= owner;
            state  <= DONE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DONE: begin
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slave request is a plain mux on the registered owner; everything except
  // the address is forced to zero outside ACTIVE.
  assign s_stb  = (state == ACTIVE);
  assign s_adr  = owner ? m1_adr : m0_adr;
  assign s_we   = s_stb & (owner ? m1_we : m0_we);
  assign s_sel  = s_stb ? (owner ? m1_sel : m0_sel) : 4'd0;
  assign s_do   = s_stb ? (owner ? m1_di : m0_di) : 32'd0;

  // One shared read buffer feeds both masters; only the acked one looks.
  assign m0_do  = rd_buf;
  assign m1_do  = rd_buf;

  assign dbg_state = state;

endmodule
